// File: rtl/snitch_pkg.sv
// Shared types for the Snitch request ordering controller.
package snitch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2,
        FULL   = 2'd3
    } order_state_e;

    localparam int PerfWidth = 32;

endpackage

// File: rtl/snitch_demux_order_ctrl_if.sv
// Request/response handshake bundle between core, ordering controller and demux.
interface snitch_demux_order_ctrl_if #(
    parameter int NrOutput = 2
);
    localparam int SelWidth = $clog2(NrOutput);

    logic                in_valid_i;
    logic                in_ready_o;
    logic [SelWidth-1:0] in_sel_i;
    logic                out_valid_o;
    logic                out_ready_i;
    logic                resp_valid_i;
    logic                resp_ready_i;
    logic [NrOutput-1:0] resp_mask_o;

    modport master (
        output in_valid_i, in_sel_i, out_ready_i, resp_valid_i, resp_ready_i,
        input  in_ready_o, out_valid_o, resp_mask_o
    );

    modport slave (
        input  in_valid_i, in_sel_i, out_ready_i, resp_valid_i, resp_ready_i,
        output in_ready_o, out_valid_o, resp_mask_o
    );

endinterface

// File: rtl/snitch_outstanding_cnt.sv
// In-flight request counter: saturates at MaxOutstanding and raises a sticky
// error when a response arrives with nothing outstanding (count never wraps).
module snitch_outstanding_cnt #(
    parameter int MaxOutstanding = 8,
    localparam int CntWidth = $clog2(MaxOutstanding + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                i_inc,
    input  logic                i_dec,
    output logic [CntWidth-1:0] o_cnt,
    output logic [CntWidth-1:0] o_cnt_next,
    output logic                o_err
);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

    logic [CntWidth-1:0] r_cnt;
    logic [CntWidth-1:0] w_cnt_next;
    logic                r_err;
    logic                w_underflow;

    assign w_underflow = i_dec && (r_cnt == '0);

    always_comb begin
        w_cnt_next = r_cnt;
        if (i_inc && !i_dec && (r_cnt != CntMax)) begin
            w_cnt_next = r_cnt + CntWidth'(1);
        end else if (i_dec && !i_inc && !w_underflow) begin
            w_cnt_next = r_cnt - CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            r_err <= r_err | w_underflow;
        end
    end

    assign o_cnt      = r_cnt;
    assign o_cnt_next = w_cnt_next;
    assign o_err      = r_err;

endmodule

// File: rtl/snitch_demux_order_ctrl.sv
// Keeps all outstanding requests on a single demux output so the fixed-priority
// response merger can never reorder responses; also limits depth and counts drain stalls.
module snitch_demux_order_ctrl
    import snitch_pkg::*;
#(
    parameter int NrOutput = 2,
    parameter int MaxOutstanding = 8,
    localparam int CntWidth = $clog2(MaxOutstanding + 1),
    localparam int SelWidth = $clog2(NrOutput)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    snitch_demux_order_ctrl_if.slave   bus,
    input  logic                       clear_perf_i,
    output logic                       busy_o,
    output logic                       err_o,
    output logic [PerfWidth-1:0]       perf_drain_stall_o
);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

    order_state_e         r_state;
    order_state_e         w_state_next;
    logic [SelWidth-1:0]  r_sel;
    logic [PerfWidth-1:0] r_perf;
    logic [CntWidth-1:0]  w_cnt;
    logic [CntWidth-1:0]  w_cnt_next;
    logic                 w_pass;
    logic                 w_accept;
    logic                 w_resp;
    logic                 w_conflict;

    // The pass decision uses only registered state, so a response can never
    // combinationally unblock a request in the same cycle.
    assign w_pass     = (w_cnt == '0) | ((bus.in_sel_i == r_sel) & (w_cnt != CntMax));
    assign w_accept   = bus.in_valid_i & bus.out_ready_i & w_pass;
    assign w_resp     = bus.resp_valid_i & bus.resp_ready_i;
    assign w_conflict = bus.in_valid_i & (bus.in_sel_i != r_sel);

    assign bus.out_valid_o = bus.in_valid_i & w_pass;
    assign bus.in_ready_o  = bus.out_ready_i & w_pass;
    assign bus.resp_mask_o = (w_cnt != '0) ? (NrOutput'(1) << r_sel) : '0;

    snitch_outstanding_cnt #(
        .MaxOutstanding (MaxOutstanding)
    ) u_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i_inc      (w_accept),
        .i_dec      (w_resp),
        .o_cnt      (w_cnt),
        .o_cnt_next (w_cnt_next),
        .o_err      (err_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sel   <= '0;
            r_state <= IDLE;
        end else begin
            if (w_accept) begin
                r_sel <= bus.in_sel_i;
            end
            r_state <= w_state_next;
        end
    end

    // Empty and full override the per-state transitions.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)            w_state_next = ACTIVE;
            ACTIVE:  if (w_conflict)          w_state_next = DRAIN;
            DRAIN:   if (!w_conflict)         w_state_next = ACTIVE;
            FULL:    if (w_resp && !w_accept) w_state_next = ACTIVE;
            default:                          w_state_next = IDLE;
        endcase
        if (w_cnt_next == '0) begin
            w_state_next = IDLE;
        end else if (w_cnt_next == CntMax) begin
            w_state_next = FULL;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_perf <= '0;
        end else if (clear_perf_i) begin
            r_perf <= '0;
        end else if ((r_state == DRAIN) && (r_perf != '1)) begin
            r_perf <= r_perf + PerfWidth'(1);
        end
    end

    assign busy_o             = (r_state != IDLE);
    assign perf_drain_stall_o = r_perf;

    a_sel_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.in_valid_i |-> (int'(bus.in_sel_i) < NrOutput));

    a_valid_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (bus.in_valid_i && !bus.in_ready_o) |=> bus.in_valid_i);

    a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_cnt <= CntMax);

endmodule

// File: tb/tb_snitch_demux_order_ctrl.sv
// Directed plus randomized bench for the ordering controller, checked against
// a count/selection reference model of the ordering rules.
module tb_snitch_demux_order_ctrl;
    localparam int NrOutput = 2;
    localparam int MaxOut   = 8;

    logic        clk  = 1'b0;
    logic        rstN = 1'b0;
    logic        clearPerf;
    logic        busy;
    logic        err;
    logic [31:0] perf;

    int numAsserts = 0;
    int numFails   = 0;

    // Reference model: outstanding count, active output, sticky error, perf,
    // whether last cycle showed a conflicting request with work in flight (not full),
    // and whether the upstream request must be held this cycle.
    int          mCnt;
    logic        mSel;
    logic        mErr;
    logic [31:0] mPerf;
    logic        mPrevConflict;
    logic        mHold;

    logic sV, sS, sOrdy, sRv, sRr, sClr;
    logic lastInReady, lastOutValid;
    logic rV, rS, rOrdy, rRv, rRr, rClr;

    always #5 clk = ~clk;

    snitch_demux_order_ctrl_if #(.NrOutput(NrOutput)) bus ();

    snitch_demux_order_ctrl #(
        .NrOutput       (NrOutput),
        .MaxOutstanding (MaxOut)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rstN),
        .bus                (bus),
        .clear_perf_i       (clearPerf),
        .busy_o             (busy),
        .err_o              (err),
        .perf_drain_stall_o (perf)
    );

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        numAsserts++;
        assert (obs === exp) else begin
            numFails++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic modelPass(input logic s);
        return (mCnt == 0) || ((s == mSel) && (mCnt != MaxOut));
    endfunction

    task automatic driveBus();
        bus.in_valid_i   = sV;
        bus.in_sel_i     = sS;
        bus.out_ready_i  = sOrdy;
        bus.resp_valid_i = sRv;
        bus.resp_ready_i = sRr;
        clearPerf        = sClr;
    endtask

    task automatic checkOutput(input string tag);
        logic pass;
        pass = modelPass(sS);
        lastInReady  = bus.in_ready_o;
        lastOutValid = bus.out_valid_o;
        checkValue({tag, ".outValid"}, 32'(bus.out_valid_o), 32'(sV && pass));
        checkValue({tag, ".inReady"},  32'(bus.in_ready_o),  32'(sOrdy && pass));
        checkValue({tag, ".respMask"}, 32'(bus.resp_mask_o),
                   (mCnt != 0) ? (32'd1 << mSel) : 32'd0);
        checkValue({tag, ".busy"}, 32'(busy), 32'(mCnt != 0));
        checkValue({tag, ".err"},  32'(err),  32'(mErr));
        checkValue({tag, ".perf"}, perf, mPerf);
    endtask

    task automatic applyStimulus(input logic v, input logic s, input logic ordy,
                                 input logic rv, input logic rr, input logic clr,
                                 input string tag);
        logic pass, acc, rsp, drainNow, nConflict, nErr, nSel;
        int nCnt;
        logic [31:0] nPerf;
        sV = v; sS = s; sOrdy = ordy; sRv = rv; sRr = rr; sClr = clr;
        driveBus();
        #1;
        checkOutput(tag);
        pass      = modelPass(s);
        acc       = v && ordy && pass;
        rsp       = rv && rr;
        drainNow  = mPrevConflict && (mCnt > 0) && (mCnt < MaxOut);
        nConflict = (mCnt > 0) && (mCnt < MaxOut) && v && (s != mSel);
        if (acc && !rsp)                  nCnt = mCnt + 1;
        else if (rsp && !acc && mCnt > 0) nCnt = mCnt - 1;
        else                              nCnt = mCnt;
        nErr  = mErr || (rsp && (mCnt == 0));
        nSel  = acc ? s : mSel;
        if (clr)                                      nPerf = 32'd0;
        else if (drainNow && (mPerf != 32'hFFFF_FFFF)) nPerf = mPerf + 32'd1;
        else                                          nPerf = mPerf;
        @(posedge clk);
        mCnt = nCnt; mErr = nErr; mSel = nSel; mPerf = nPerf;
        mPrevConflict = nConflict;
        mHold = v && !acc;
        @(negedge clk);
    endtask

    task automatic doReset(input string tag);
        rstN = 1'b0;
        sV = 1'b0; sS = 1'b0; sOrdy = 1'b1; sRv = 1'b0; sRr = 1'b0; sClr = 1'b0;
        driveBus();
        #1;
        mCnt = 0; mSel = 1'b0; mErr = 1'b0; mPerf = 32'd0;
        mPrevConflict = 1'b0; mHold = 1'b0;
        checkOutput(tag);
        @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic drainAll(input string tag);
        for (int k = 0; k < 60; k++) begin
            if ((mCnt == 0) && !mHold) break;
            applyStimulus(mHold, sS, 1'b1, (mCnt > 0), 1'b1, 1'b0, tag);
        end
        checkValue({tag, ".drained"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        doReset("reset");
        checkValue("reset.inReady", 32'(lastInReady), 32'd1);
        checkValue("reset.busy", 32'(busy), 32'd0);
        checkValue("reset.err",  32'(err),  32'd0);
        checkValue("reset.perf", perf, 32'd0);

        // Back-to-back requests to output 1
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 1, 0, 0, 0, "t1.req");
        applyStimulus(0, 1, 1, 0, 0, 0, "t1.idle");
        checkValue("t1.mask", 32'(bus.resp_mask_o), 32'd2);
        checkValue("t1.busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 1, 1, 0, "t1.resp");
        checkValue("t1.idleAfter", 32'(busy), 32'd0);

        // Conflicting request waits until output 0 drains
        for (int i = 0; i < 2; i++) applyStimulus(1, 0, 1, 0, 0, 0, "t2.acc");
        applyStimulus(1, 1, 1, 0, 0, 0, "t2.c0");
        checkValue("t2.blocked", 32'(lastOutValid), 32'd0);
        applyStimulus(1, 1, 1, 0, 0, 0, "t2.c1");
        applyStimulus(1, 1, 1, 1, 1, 0, "t2.c2");
        applyStimulus(1, 1, 1, 1, 1, 0, "t2.c3");
        checkValue("t2.sameCycleBlocked", 32'(lastOutValid), 32'd0);
        applyStimulus(1, 1, 1, 0, 0, 0, "t2.c4");
        checkValue("t2.accepted", 32'(lastOutValid), 32'd1);
        checkValue("t2.perf", perf, 32'd3);
        applyStimulus(0, 1, 1, 1, 1, 1, "t2.clr");
        checkValue("t2.perfClr", perf, 32'd0);

        // Depth limit
        for (int i = 0; i < MaxOut; i++) applyStimulus(1, 0, 1, 0, 0, 0, "t3.fill");
        applyStimulus(1, 0, 1, 0, 0, 0, "t3.ninth");
        checkValue("t3.ninthBlocked", 32'(lastInReady), 32'd0);
        applyStimulus(1, 0, 1, 1, 1, 0, "t3.ninthResp");
        checkValue("t3.respNoUnblock", 32'(lastInReady), 32'd0);
        applyStimulus(1, 0, 1, 0, 0, 0, "t3.ninthAcc");
        checkValue("t3.ninthAccepted", 32'(lastInReady), 32'd1);
        for (int i = 0; i < MaxOut - 1; i++) applyStimulus(0, 0, 1, 1, 1, 0, "t3.drain");
        checkValue("t3.oneLeft", 32'(busy), 32'd1);
        applyStimulus(0, 0, 1, 1, 1, 0, "t3.last");
        checkValue("t3.empty", 32'(busy), 32'd0);

        // Accept and response in the same cycle
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 0, 0, 0, "t4.fill");
        applyStimulus(1, 1, 1, 1, 1, 0, "t4.accResp");
        checkValue("t4.accepted", 32'(lastInReady), 32'd1);
        for (int i = 0; i < 2; i++) applyStimulus(0, 1, 1, 1, 1, 0, "t4.drain");
        checkValue("t4.mask", 32'(bus.resp_mask_o), 32'd2);
        checkValue("t4.busy", 32'(busy), 32'd1);
        applyStimulus(0, 1, 1, 1, 1, 0, "t4.last");
        checkValue("t4.empty", 32'(busy), 32'd0);

        // Random traffic, upstream holds blocked requests stable
        for (int i = 0; i < 400; i++) begin
            if (mHold) begin
                rV = 1'b1;
                rS = sS;
            end else begin
                rV = ($urandom_range(0, 99) < 60);
                rS = 1'($urandom_range(0, 1));
            end
            rOrdy = ($urandom_range(0, 3) != 0);
            rRv   = (mCnt > 0) && ($urandom_range(0, 1) == 1);
            rRr   = ($urandom_range(0, 3) != 0);
            rClr  = ($urandom_range(0, 49) == 0);
            applyStimulus(rV, rS, rOrdy, rRv, rRr, rClr, "rand");
        end
        drainAll("randDrain");

        // Underflow: count stays zero, error is sticky
        applyStimulus(0, 0, 1, 1, 1, 0, "t5.underflow");
        checkValue("t5.errSet", 32'(err), 32'd1);
        checkValue("t5.maskZero", 32'(bus.resp_mask_o), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0, 0, "t5.idle");
        checkValue("t5.errSticky", 32'(err), 32'd1);
        applyStimulus(1, 0, 1, 0, 0, 0, "t5.acc");
        applyStimulus(0, 0, 1, 1, 1, 0, "t5.resp");
        checkValue("t5.noWrap", 32'(busy), 32'd0);

        // Reset mid-drain, then clear perf while draining
        doReset("t6.pre");
        checkValue("t6.errCleared", 32'(err), 32'd0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 1, 0, 0, 0, "t6.fill");
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 0, 0, 0, "t6.conflict");
        checkValue("t6.perfBefore", perf, 32'd2);
        doReset("t6.rst");
        checkValue("t6.busy", 32'(busy), 32'd0);
        checkValue("t6.mask", 32'(bus.resp_mask_o), 32'd0);
        checkValue("t6.perf", perf, 32'd0);
        for (int i = 0; i < 2; i++) applyStimulus(1, 0, 1, 0, 0, 0, "t6.fill2");
        applyStimulus(1, 1, 1, 0, 0, 0, "t6.c0");
        applyStimulus(1, 1, 1, 0, 0, 1, "t6.c1clr");
        checkValue("t6.perfClrInDrain", perf, 32'd0);
        applyStimulus(1, 1, 1, 0, 0, 0, "t6.c2");
        checkValue("t6.perfCounts", perf, 32'd1);
        drainAll("t6.drain");

        $display("End of test - %0d assertions evaluated, %0d failures", numAsserts, numFails);
        $finish;
    end

endmodule
